// File: rtl/seq_det_rr_sched_if.sv
// ============================================================================
//  Module      : seq_det_rr_sched_if
//  Description : Request/grant and detection-report bundle for the shared
//                round-robin pattern-detector engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_det_rr_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           en;
    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] gnt;
    logic           det_valid;
    logic [CHW-1:0] det_ch;
    logic [CW-1:0]  det_cnt;

    // Source / status side
    modport master (
        output en, req, bit_in,
        input  gnt, det_valid, det_ch, det_cnt
    );

    // Detector engine side
    modport slave (
        input  en, req, bit_in,
        output gnt, det_valid, det_ch, det_cnt
    );
endinterface

`default_nettype wire

// File: rtl/seq_det_rr_sched.sv
// ============================================================================
//  Module      : seq_det_rr_sched
//  Description : One overlapping serial pattern detector time-shared among NCH
//                bit-stream channels through a round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_rr_sched #(
    parameter int             NCH     = 4,
    parameter int             PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter int             CW      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_det_rr_sched_if.slave  bus
);
    localparam int          CHW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          CTXW      = $clog2(PLEN);
    localparam logic [31:0] c_PAT     = 32'(PATTERN);
    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};

    // Integer value of the first l pattern bits (first-received bit is MSB).
    function automatic int f_prefix(input int l);
        return int'(c_PAT >> (PLEN - l));
    endfunction

    // Longest proper pattern prefix that is a suffix of prefix(k) followed by b.
    // Capping at PLEN-1 makes a full match fall back to the overlap length.
    function automatic int f_next(input int k, input int b);
        int s;
        int res;
        s   = (f_prefix(k) << 1) | b;
        res = 0;
        for (int l = 1; l < PLEN; l++) begin
            if (l <= k + 1 && (s & ((1 << l) - 1)) == f_prefix(l))
                res = l;
        end
        return res;
    endfunction

    function automatic logic f_hit(input int k, input int b);
        return (k == PLEN - 1) && (((f_prefix(k) << 1) | b) == f_prefix(PLEN));
    endfunction

    logic [CTXW-1:0] w_ns_tab  [PLEN][2];
    logic            w_hit_tab [PLEN][2];

    generate
        for (genvar k = 0; k < PLEN; k++) begin : g_state
            for (genvar b = 0; b < 2; b++) begin : g_bit
                assign w_ns_tab[k][b]  = CTXW'(f_next(k, b));
                assign w_hit_tab[k][b] = f_hit(k, b);
            end
        end
    endgenerate

    logic [CTXW-1:0] r_ctx [NCH];
    logic [CHW-1:0]  r_ptr;
    logic            r_det_valid;
    logic [CHW-1:0]  r_det_ch;
    logic [CW-1:0]   r_det_cnt;

    logic            w_any;
    logic [CHW-1:0]  w_gidx;
    logic [NCH-1:0]  w_gnt;
    logic [CHW-1:0]  w_ptr_nxt;
    logic [CTXW-1:0] w_ctx;
    logic            w_bit;
    logic [CTXW-1:0] w_ns;
    logic            w_hit;

    // Search starts at the pointer and wraps; first requester wins.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_gidx = '0;
        idx    = 0;
        if (!rst && bus.en) begin
            for (int i = 0; i < NCH; i++) begin
                idx = int'(r_ptr) + i;
                if (idx >= NCH)
                    idx = idx - NCH;
                if (!w_any && bus.req[idx]) begin
                    w_any  = 1'b1;
                    w_gidx = CHW'(idx);
                end
            end
        end
        w_gnt = w_any ? (NCH'(1) << w_gidx) : '0;
    end

    assign w_ptr_nxt = (int'(w_gidx) == NCH - 1) ? '0 : w_gidx + 1'b1;
    assign w_ctx     = r_ctx[w_gidx];
    assign w_bit     = bus.bit_in[w_gidx];
    assign w_ns      = w_ns_tab[w_ctx][w_bit];
    assign w_hit     = w_hit_tab[w_ctx][w_bit];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                r_ctx[i] <= '0;
            r_ptr       <= '0;
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
            r_det_cnt   <= '0;
        end else begin
            r_det_valid <= 1'b0;
            if (w_any) begin
                r_ptr         <= w_ptr_nxt;
                r_ctx[w_gidx] <= w_ns;
                if (w_hit) begin
                    r_det_valid <= 1'b1;
                    r_det_ch    <= w_gidx;
                    if (r_det_cnt != c_CNT_MAX)
                        r_det_cnt <= r_det_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.det_valid = r_det_valid;
    assign bus.det_ch    = r_det_ch;
    assign bus.det_cnt   = r_det_cnt;

endmodule

`default_nettype wire
